uart_core: RTL
==============

UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 The block SHALL have one parameter: CLKS_PER_BIT, default 868 (100 MHz / 115200 baud), giving clock cycles per serial bit, legal range 4..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port tx_data, input, 8 bits: byte to transmit, sampled when tx_we=1.
REQ-005 The block SHALL have port tx_we, input, 1 bit: single-cycle transmit request from the core's store to 0x1000_0000.
REQ-006 The block SHALL have port tx_busy, output, 1 bit: transmitter occupied; tx_we is ignored while high.
REQ-007 The block SHALL have port rx_data, output, 8 bits: last received byte (holding register).
REQ-008 The block SHALL have port rx_valid, output, 1 bit: holding register contains an unread byte.
REQ-009 The block SHALL have port rx_re, input, 1 bit: read acknowledge from the core's load of 0x1000_0000.
REQ-010 The block SHALL have port uart_rxd, input, 1 bit: asynchronous serial input, idle high.
REQ-011 The block SHALL have port uart_txd, output, 1 bit: serial output, idle high.
REQ-012 The block SHALL have port rx_overrun, output, 1 bit: one-cycle pulse when an unread byte is overwritten.
REQ-013 The block SHALL have port rx_frame_err, output, 1 bit: one-cycle pulse when a received stop bit samples low.

Function
REQ-014 The frame format SHALL be 8N1: start bit 0, eight data bits LSB first, one stop bit 1; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-015 The TX FSM SHALL have states T_IDLE -> T_START -> T_DATA (3-bit index 0..7) -> T_STOP -> T_IDLE, with each state advanced by a bit counter that wraps at CLKS_PER_BIT-1.
REQ-016 tx_we=1 with tx_busy=0 in cycle N SHALL latch tx_data, set tx_busy=1 and drive uart_txd=0 from cycle N+1.
REQ-017 tx_busy SHALL fall in cycle N+1+10*CLKS_PER_BIT (end of the stop bit); a tx_we in that same cycle SHALL start a new frame back-to-back.
REQ-018 tx_we while tx_busy=1 SHALL be dropped without affecting the frame in flight.
REQ-019 uart_rxd SHALL pass through a two-flop synchronizer before any use.
REQ-020 The RX FSM SHALL have states R_IDLE -> R_START -> R_DATA -> R_STOP -> R_IDLE; R_IDLE leaves on a synchronized low.
REQ-021 R_START SHALL sample at CLKS_PER_BIT/2 (integer division); a high sample is a false start and SHALL return to R_IDLE with no flags set.
REQ-022 Data bits and the stop bit SHALL be sampled at bit centres (every CLKS_PER_BIT cycles after the start-centre sample).
REQ-023 A stop sample of 1 SHALL load rx_data and set rx_valid=1 in the next cycle.
REQ-024 A stop sample of 0 SHALL discard the byte, pulse rx_frame_err, leave rx_data/rx_valid unchanged, and return to R_IDLE only after uart_rxd is seen high.
REQ-025 rx_re=1 SHALL clear rx_valid in the next cycle; rx_re while rx_valid=0 SHALL have no effect.
REQ-026 A byte completing while rx_valid=1 and rx_re=0 SHALL overwrite rx_data, keep rx_valid=1 and pulse rx_overrun.
REQ-027 A byte completing in the same cycle as rx_re=1 SHALL load the new byte with rx_valid=1 and SHALL NOT pulse rx_overrun.
REQ-028 TX and RX SHALL operate fully independently, including at full duplex.

Reset
REQ-029 While rst=0 the block SHALL hold uart_txd=1, tx_busy=0, rx_data=0x00, rx_valid=0, rx_overrun=0, rx_frame_err=0, both FSMs in idle, all counters at 0 and synchronizer flops at 1.
REQ-030 Reset asserted mid-frame SHALL abort both directions immediately; after release, TX SHALL only start on a fresh tx_we, and RX SHALL wait for a new falling edge.

Structure
REQ-031 TX/RX state encodings and the default CLKS_PER_BIT SHALL live in a shared package, uart_pkg.
REQ-032 The receiver SHALL be a sub-module, uart_rx, instantiated once; the transmitter and holding-register logic SHALL live in uart_core.

Verification (CLKS_PER_BIT=16)
REQ-033 tx_we pulse with tx_data=0xA5 at cycle N -> uart_txd sequence 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles; tx_busy high N+1..N+160, low at N+161.
REQ-034 Second tx_we with 0x3C at N+5 during the 0xA5 frame -> ignored; the 0xA5 frame is unaltered and uart_txd returns high after the stop bit.
REQ-035 Serial 0x5A driven on uart_rxd -> rx_data=0x5A and rx_valid=1; rx_re pulse -> rx_valid=0 the next cycle.
REQ-036 Frames 0x11 then 0x22 with no rx_re -> one rx_overrun pulse and rx_data=0x22; repeat with rx_re coinciding with 0x22 completion -> no overrun pulse.
REQ-037 Stop bit forced to 0 -> rx_frame_err pulse and rx_valid unchanged; a 4-cycle low glitch -> no flags, FSM back in R_IDLE.
REQ-038 rst pulsed low mid-TX at bit 3 -> uart_txd=1 and tx_busy=0 immediately; the next tx_we sends a complete frame.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants and FSM encodings for the 8N1 UART core.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DEF_CLKS_PER_BIT = 868;
    localparam int CNT_W            = 16;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_START = 2'd1,
        T_DATA  = 2'd2,
        T_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 receiver with input synchronizer, centre sampling and stop check.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] byte_data,
    output logic       byte_done,
    output logic       frame_err
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_half = CNT_W'(CLKS_PER_BIT / 2);

    logic             r_sync1;
    logic             r_sync2;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_break;
    logic             r_frame_err;
    logic             w_tick;

    assign w_tick    = (r_cnt == c_last);
    assign byte_data = r_shift;
    assign frame_err = r_frame_err;
    // Completion is decoded from the stop sample so the holding register loads one cycle later
    assign byte_done = (r_state == R_STOP) && !r_break && w_tick && r_sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= R_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_break     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= rxd;
            r_sync2     <= r_sync1;
            r_frame_err <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    r_cnt   <= '0;
                    r_break <= 1'b0;
                    if (!r_sync2) r_state <= R_START;
                end
                R_START: begin
                    if (r_cnt == c_half) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= r_sync2 ? R_IDLE : R_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == 3'd7) r_state <= R_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    // After a bad stop bit, hold here until the line returns high
                    if (r_break) begin
                        if (r_sync2) r_state <= R_IDLE;
                    end else if (w_tick) begin
                        r_cnt <= '0;
                        if (r_sync2) begin
                            r_state <= R_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_break     <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_core.sv
// ============================================================================
// Module   : uart_core
// Brief    : 8N1 UART: transmitter, receive holding register and uart_rx instance.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_we,
    output logic       tx_busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_re,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        r_tx_state;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [2:0]       r_tx_idx;
    logic [7:0]       r_tx_shift;
    logic             w_tx_tick;
    logic [7:0]       w_rx_byte;
    logic             w_rx_done;

    assign w_tx_tick = (r_tx_cnt == c_last);

    // tx_busy is low only in T_IDLE, so a request is accepted there and nowhere else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= T_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            uart_txd   <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            case (r_tx_state)
                T_IDLE: begin
                    r_tx_cnt <= '0;
                    if (tx_we) begin
                        r_tx_shift <= tx_data;
                        uart_txd   <= 1'b0;
                        tx_busy    <= 1'b1;
                        r_tx_state <= T_START;
                    end
                end
                T_START: begin
                    if (w_tx_tick) begin
                        r_tx_cnt   <= '0;
                        r_tx_idx   <= '0;
                        uart_txd   <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_state <= T_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                T_DATA: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= '0;
                        r_tx_idx <= r_tx_idx + 1'b1;
                        if (r_tx_idx == 3'd7) begin
                            uart_txd   <= 1'b1;
                            r_tx_state <= T_STOP;
                        end else begin
                            uart_txd   <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                T_STOP: begin
                    if (w_tx_tick) begin
                        r_tx_cnt   <= '0;
                        tx_busy    <= 1'b0;
                        r_tx_state <= T_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= T_IDLE;
            endcase
        end
    end

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rxd       (uart_rxd),
        .byte_data (w_rx_byte),
        .byte_done (w_rx_done),
        .frame_err (rx_frame_err)
    );

    // A read acknowledged in the completion cycle consumes the old byte, so no overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else if (w_rx_done) begin
            rx_data    <= w_rx_byte;
            rx_valid   <= 1'b1;
            rx_overrun <= rx_valid && !rx_re;
        end else begin
            rx_overrun <= 1'b0;
            if (rx_re) rx_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire
